// File: rtl/music_pkg.sv
// Shared constants and types for the music player voice path.
//   NumVoices  : number of note_player voices
//   NoteW/DurW : note code and duration widths (note code 0 is a rest)
//   disp_state_e : note_dispatcher FSM states
package music_pkg;

   localparam int unsigned NumVoices = 3;
   localparam int unsigned NoteW     = 6;
   localparam int unsigned DurW      = 6;
   localparam int unsigned VoiceIdxW = (NumVoices > 1) ? $clog2(NumVoices) : 1;

   localparam logic [NoteW-1:0] NoteRest = '0;

   typedef enum logic [1:0] {
      StIdle,
      StAccept,
      StLoad,
      StBarrier
   } disp_state_e;

endpackage

// File: rtl/note_dispatcher_if.sv
// Note handshake between song_reader (master) and note_dispatcher (slave).
//   note_valid : producer has a note
//   note       : note code (0 = rest)
//   duration   : note length in beats
//   note_sync  : chord barrier after this note
//   note_ready : dispatcher takes the note this cycle
interface note_dispatcher_if;

   logic                         note_valid;
   logic [music_pkg::NoteW-1:0]  note;
   logic [music_pkg::DurW-1:0]   duration;
   logic                         note_sync;
   logic                         note_ready;

   modport master (
      output note_valid,
      output note,
      output duration,
      output note_sync,
      input  note_ready
   );

   modport slave (
      input  note_valid,
      input  note,
      input  duration,
      input  note_sync,
      output note_ready
   );

endinterface

// File: rtl/rr_free_picker.sv
// Combinational round-robin free-voice finder.
//   busy_i   : per-voice busy vector
//   rr_ptr_i : index to start searching from
//   found_o  : at least one voice is free
//   idx_o    : first free voice at/after rr_ptr_i, wrapping
module rr_free_picker #(
   parameter int unsigned NumVoices = 3,
   parameter int unsigned IdxW      = 2
) (
   input  logic [NumVoices-1:0] busy_i,
   input  logic [IdxW-1:0]      rr_ptr_i,
   output logic                 found_o,
   output logic [IdxW-1:0]      idx_o
);

   always_comb begin
      logic [IdxW-1:0] j;
      found_o = 1'b0;
      idx_o   = '0;
      j       = '0;
      // Scan farthest-first so the nearest free voice is the last write.
      for (int k = NumVoices - 1; k >= 0; k--) begin
         j = IdxW'((32'(rr_ptr_i) + $unsigned(k)) % NumVoices);
         if (!busy_i[j]) begin
            found_o = 1'b1;
            idx_o   = j;
         end
      end
   end

endmodule

// File: rtl/note_dispatcher.sv
// Allocates incoming notes to free note_player voices round-robin, tracks
// per-voice busy state and holds off the next group at chord barriers.
//   clk, reset_n     : clock, asynchronous active-low reset
//   play_i           : 0 = paused
//   flush_i          : one-cycle pulse, returns the dispatcher to idle
//   note_if          : note handshake (slave side)
//   voice_load_o     : one-hot load pulse to the chosen voice
//   voice_note_o     : shared note bus, valid with voice_load_o
//   voice_duration_o : shared duration bus, valid with voice_load_o
//   voice_done_i     : per-voice done pulses
//   voice_busy_o     : per-voice busy flags
//   all_idle_o       : no voice busy
module note_dispatcher
   import music_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 play_i,
   input  logic                 flush_i,
   note_dispatcher_if.slave     note_if,
   output logic [NumVoices-1:0] voice_load_o,
   output logic [NoteW-1:0]     voice_note_o,
   output logic [DurW-1:0]      voice_duration_o,
   input  logic [NumVoices-1:0] voice_done_i,
   output logic [NumVoices-1:0] voice_busy_o,
   output logic                 all_idle_o
);

   disp_state_e            state_q, state_d;
   logic [VoiceIdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NumVoices-1:0]   busy_q, busy_d;
   logic [NumVoices-1:0]   load_q, load_d;
   logic [NoteW-1:0]       vnote_q, vnote_d;
   logic [DurW-1:0]        vdur_q, vdur_d;
   logic                   ready_q, ready_d;
   logic                   idle_q, idle_d;
   logic                   sync_q, sync_d;

   logic                   found;
   logic [VoiceIdxW-1:0]   pick_idx;
   logic                   take;
   logic                   is_rest;

   rr_free_picker #(
      .NumVoices (NumVoices),
      .IdxW      (VoiceIdxW)
   ) u_picker (
      .busy_i   (busy_q),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (found),
      .idx_o    (pick_idx)
   );

   assign is_rest = (note_if.note == NoteRest);
   // A flush in the same cycle cancels the handshake.
   assign take    = note_if.note_valid & ready_q & ~flush_i;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      load_d   = '0;
      vnote_d  = vnote_q;
      vdur_d   = vdur_q;
      sync_d   = sync_q;

      // Rests are consumed without a voice. If the note changed to a real
      // one after ready was computed from a rest and nothing is free, it is
      // dropped rather than overwriting a busy voice.
      if (take && !is_rest && found) begin
         load_d[pick_idx] = 1'b1;
         rr_ptr_d = (pick_idx == VoiceIdxW'(NumVoices - 1)) ? '0
                                                            : pick_idx + VoiceIdxW'(1);
         vnote_d  = note_if.note;
         vdur_d   = note_if.duration;
      end

      // Load beats a same-cycle done on the same voice.
      busy_d = (busy_q & ~voice_done_i) | load_d;

      unique case (state_q)
         StIdle: begin
            if (play_i) state_d = StAccept;
         end
         StAccept: begin
            // A committed handshake completes even if play drops with it.
            if (take) begin
               state_d = StLoad;
               sync_d  = note_if.note_sync;
            end else if (!play_i) begin
               state_d = StIdle;
            end
         end
         StLoad: begin
            state_d = sync_q ? StBarrier : StAccept;
         end
         StBarrier: begin
            if (!play_i)     state_d = StIdle;
            else if (idle_q) state_d = StAccept;
         end
         default: state_d = StIdle;
      endcase

      if (flush_i) begin
         state_d  = StIdle;
         busy_d   = '0;
         load_d   = '0;
         rr_ptr_d = '0;
         sync_d   = 1'b0;
      end

      idle_d  = ~|busy_d;
      // Ready looks at the current busy vector, so it rises the cycle after
      // a done has cleared a voice.
      ready_d = ~flush_i & play_i & (state_d == StAccept) & (found | is_rest);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         busy_q   <= '0;
         load_q   <= '0;
         vnote_q  <= '0;
         vdur_q   <= '0;
         ready_q  <= 1'b0;
         idle_q   <= 1'b1;
         sync_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         load_q   <= load_d;
         vnote_q  <= vnote_d;
         vdur_q   <= vdur_d;
         ready_q  <= ready_d;
         idle_q   <= idle_d;
         sync_q   <= sync_d;
      end
   end

   assign note_if.note_ready = ready_q;
   assign voice_load_o       = load_q;
   assign voice_note_o       = vnote_q;
   assign voice_duration_o   = vdur_q;
   assign voice_busy_o       = busy_q;
   assign all_idle_o         = idle_q;

endmodule
